// File: rtl/rf_wb_if.sv
// Register-file write-port arbiter bus: pipeline writeback, load unit results,
// hazard queries and the register-file write port.
interface rf_wb_if;
   logic        pipe_wb_valid;
   logic [4:0]  pipe_wb_rd;
   logic [31:0] pipe_wb_data;
   logic        pipe_stall;
   logic        ld_issue;
   logic [4:0]  ld_issue_rd;
   logic        ld_valid;
   logic [4:0]  ld_rd;
   logic [31:0] ld_data;
   logic        ld_ready;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [4:0]  rd_q;
   logic        rs1_pending;
   logic        rs2_pending;
   logic        rd_pending;
   logic        rf_write;
   logic [4:0]  A3;
   logic [31:0] WB_data;

   modport slave (
      input  pipe_wb_valid, pipe_wb_rd, pipe_wb_data,
      input  ld_issue, ld_issue_rd, ld_valid, ld_rd, ld_data,
      input  rs1, rs2, rd_q,
      output pipe_stall, ld_ready, rs1_pending, rs2_pending, rd_pending,
      output rf_write, A3, WB_data
   );

   modport master (
      output pipe_wb_valid, pipe_wb_rd, pipe_wb_data,
      output ld_issue, ld_issue_rd, ld_valid, ld_rd, ld_data,
      output rs1, rs2, rd_q,
      input  pipe_stall, ld_ready, rs1_pending, rs2_pending, rd_pending,
      input  rf_write, A3, WB_data
   );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port between pipeline writeback (priority) and a
// buffered load-result queue, with a starvation-forced drain slot and a pending-load scoreboard.
module rf_wb_arbiter #(
   parameter int unsigned LQ_DEPTH     = 4,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic   clk,
   input  logic   rst,
   rf_wb_if.slave bus
);

   localparam int unsigned PTR_W = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [0:0] {NORMAL, FORCE} state_t;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } lq_entry_t;

   lq_entry_t        mem [LQ_DEPTH];
   lq_entry_t        head;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             empty;
   logic             full;
   logic             push;
   logic             pop;
   logic             pipe_sel;

   logic [31:0]      sb;
   logic [31:0]      sb_d;
   logic [STV_W-1:0] starve;
   logic [STV_W-1:0] starve_d;
   state_t           state;
   state_t           state_d;
   logic             stall_q;
   logic             stall_d;

   logic             wr_en;
   logic [4:0]       wr_addr;
   logic [31:0]      wr_data;

   assign head     = mem[rd_ptr];
   assign empty    = (count == '0);
   assign full     = (count == CNT_W'(LQ_DEPTH));
   assign push     = bus.ld_valid && !full;
   assign pipe_sel = bus.pipe_wb_valid && !stall_q;
   assign pop      = !pipe_sel && !empty;

   // Write-port mux; held idle while reset is asserted
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = 5'd0;
      wr_data = 32'd0;
      if (!rst) begin
         if (pipe_sel) begin
            wr_en   = 1'b1;
            wr_addr = bus.pipe_wb_rd;
            wr_data = bus.pipe_wb_data;
         end else if (!empty) begin
            wr_en   = 1'b1;
            wr_addr = head.rd;
            wr_data = head.data;
         end
      end
   end

   // Queue pointers and occupancy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= '{rd: bus.ld_rd, data: bus.ld_data};
   end

   // Scoreboard: set is applied after clear so a same-cycle collision keeps the bit set
   always_comb begin
      sb_d = sb;
      if (pop) sb_d[head.rd] = 1'b0;
      if (bus.ld_issue && (bus.ld_issue_rd != 5'd0)) sb_d[bus.ld_issue_rd] = 1'b1;
      sb_d[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sb <= '0;
      else     sb <= sb_d;
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= NORMAL;
         starve  <= '0;
         stall_q <= 1'b0;
      end else begin
         state   <= state_d;
         starve  <= starve_d;
         stall_q <= stall_d;
      end
   end

   // FSM next state: count waiting cycles and claim one drain slot at the limit
   always_comb begin
      state_d  = state;
      starve_d = starve;
      stall_d  = 1'b0;
      case (state)
         NORMAL: begin
            if (empty || pop) begin
               starve_d = '0;
            end else if (starve == STV_W'(STARVE_LIMIT - 1)) begin
               state_d  = FORCE;
               starve_d = '0;
               stall_d  = 1'b1;
            end else begin
               starve_d = starve + STV_W'(1);
            end
         end
         FORCE: begin
            state_d  = NORMAL;
            starve_d = '0;
         end
         default: begin
            state_d  = NORMAL;
            starve_d = '0;
         end
      endcase
   end

   assign bus.pipe_stall  = stall_q;
   assign bus.ld_ready    = !full;
   assign bus.rs1_pending = sb[bus.rs1];
   assign bus.rs2_pending = sb[bus.rs2];
   assign bus.rd_pending  = sb[bus.rd_q];
   assign bus.rf_write    = wr_en;
   assign bus.A3          = wr_addr;
   assign bus.WB_data     = wr_data;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter (LQ_DEPTH=4, STARVE_LIMIT=8).
module tb_rf_wb_arbiter;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   rf_wb_if bus ();

   rf_wb_arbiter #(.LQ_DEPTH(4), .STARVE_LIMIT(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.pipe_wb_valid = 1'b0;
      bus.pipe_wb_rd    = 5'd0;
      bus.pipe_wb_data  = 32'd0;
      bus.ld_issue      = 1'b0;
      bus.ld_issue_rd   = 5'd0;
      bus.ld_valid      = 1'b0;
      bus.ld_rd         = 5'd0;
      bus.ld_data       = 32'd0;
      bus.rs1           = 5'd0;
      bus.rs2           = 5'd0;
      bus.rd_q          = 5'd0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      bus.pipe_wb_valid = 1'b1;
      bus.pipe_wb_rd    = 5'd4;
      bus.pipe_wb_data  = 32'h1234_5678;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (bus.rf_write !== 1'b0 || bus.A3 !== 5'd0 || bus.WB_data !== 32'd0) begin
         $display("FAIL reset_port_idle: got we=%b a3=%0d d=%h want 0/0/0", bus.rf_write, bus.A3, bus.WB_data);
         n_fail++;
      end
      rst = 1'b0;
      idle_inputs();
      bus.rs1 = 5'd5;
      bus.rs2 = 5'd31;
      bus.rd_q = 5'd17;
      #1;
      n_checks++;
      if (bus.rf_write !== 1'b0 || bus.ld_ready !== 1'b1 || bus.pipe_stall !== 1'b0) begin
         $display("FAIL reset_state: got we=%b rdy=%b stall=%b want 0/1/0", bus.rf_write, bus.ld_ready, bus.pipe_stall);
         n_fail++;
      end
      n_checks++;
      if ({bus.rs1_pending, bus.rs2_pending, bus.rd_pending} !== 3'b000) begin
         $display("FAIL reset_pending: got %b want 000", {bus.rs1_pending, bus.rs2_pending, bus.rd_pending});
         n_fail++;
      end
      step();
   endtask

   task automatic test_single_load();
      idle_inputs();
      bus.ld_issue    = 1'b1;
      bus.ld_issue_rd = 5'd5;
      step();
      bus.ld_issue = 1'b0;
      bus.rs1      = 5'd5;
      bus.ld_valid = 1'b1;
      bus.ld_rd    = 5'd5;
      bus.ld_data  = 32'hDEAD_BEEF;
      #1;
      n_checks++;
      if (bus.rs1_pending !== 1'b1 || bus.rf_write !== 1'b0) begin
         $display("FAIL load_push_cycle: got pend=%b we=%b want 1/0", bus.rs1_pending, bus.rf_write);
         n_fail++;
      end
      step();
      bus.ld_valid = 1'b0;
      #1;
      n_checks++;
      if (bus.rf_write !== 1'b1 || bus.A3 !== 5'd5 || bus.WB_data !== 32'hDEAD_BEEF || bus.rs1_pending !== 1'b1) begin
         $display("FAIL load_write: got we=%b a3=%0d d=%h pend=%b want 1/5/deadbeef/1",
                  bus.rf_write, bus.A3, bus.WB_data, bus.rs1_pending);
         n_fail++;
      end
      step();
      n_checks++;
      if (bus.rs1_pending !== 1'b0 || bus.rf_write !== 1'b0) begin
         $display("FAIL load_cleared: got pend=%b we=%b want 0/0", bus.rs1_pending, bus.rf_write);
         n_fail++;
      end
   endtask

   task automatic test_starve();
      idle_inputs();
      bus.ld_issue    = 1'b1;
      bus.ld_issue_rd = 5'd7;
      bus.rd_q        = 5'd7;
      step();
      bus.ld_issue      = 1'b0;
      bus.pipe_wb_valid = 1'b1;
      bus.pipe_wb_rd    = 5'd10;
      bus.pipe_wb_data  = 32'hCAFE_0010;
      bus.ld_valid      = 1'b1;
      bus.ld_rd         = 5'd7;
      bus.ld_data       = 32'h1111_2222;
      #1;
      n_checks++;
      if (bus.rf_write !== 1'b1 || bus.A3 !== 5'd10 || bus.WB_data !== 32'hCAFE_0010) begin
         $display("FAIL starve_push_pipe: got we=%b a3=%0d d=%h want 1/10/cafe0010", bus.rf_write, bus.A3, bus.WB_data);
         n_fail++;
      end
      step();
      bus.ld_valid = 1'b0;
      for (int w = 0; w < 8; w++) begin
         #1;
         n_checks++;
         if (bus.pipe_stall !== 1'b0 || bus.A3 !== 5'd10 || bus.rd_pending !== 1'b1) begin
            $display("FAIL starve_wait%0d: got stall=%b a3=%0d pend=%b want 0/10/1", w, bus.pipe_stall, bus.A3, bus.rd_pending);
            n_fail++;
         end
         step();
      end
      #1;
      n_checks++;
      if (bus.pipe_stall !== 1'b1 || bus.rf_write !== 1'b1 || bus.A3 !== 5'd7 || bus.WB_data !== 32'h1111_2222) begin
         $display("FAIL starve_force: got stall=%b we=%b a3=%0d d=%h want 1/1/7/11112222",
                  bus.pipe_stall, bus.rf_write, bus.A3, bus.WB_data);
         n_fail++;
      end
      step();
      n_checks++;
      if (bus.pipe_stall !== 1'b0 || bus.A3 !== 5'd10 || bus.rd_pending !== 1'b0) begin
         $display("FAIL starve_after: got stall=%b a3=%0d pend=%b want 0/10/0", bus.pipe_stall, bus.A3, bus.rd_pending);
         n_fail++;
      end
      idle_inputs();
      step();
   endtask

   task automatic test_full_fifo();
      logic [31:0] d [10];
      for (int i = 0; i < 10; i++) d[i] = 32'hA000_0000 + 32'(i * 17);
      idle_inputs();
      bus.pipe_wb_valid = 1'b1;
      bus.pipe_wb_rd    = 5'd3;
      bus.pipe_wb_data  = 32'h0BAD_F00D;
      for (int i = 0; i < 4; i++) begin
         bus.ld_valid = 1'b1;
         bus.ld_rd    = 5'(i + 1);
         bus.ld_data  = d[i];
         #1;
         n_checks++;
         if (bus.ld_ready !== 1'b1 || bus.A3 !== 5'd3) begin
            $display("FAIL fill%0d: got rdy=%b a3=%0d want 1/3", i, bus.ld_ready, bus.A3);
            n_fail++;
         end
         step();
      end
      bus.ld_rd   = 5'd5;
      bus.ld_data = d[4];
      for (int h = 0; h < 2; h++) begin
         #1;
         n_checks++;
         if (bus.ld_ready !== 1'b0) begin
            $display("FAIL full_hold%0d: got rdy=%b want 0", h, bus.ld_ready);
            n_fail++;
         end
         step();
      end
      bus.pipe_wb_valid = 1'b0;
      #1;
      n_checks++;
      if (bus.ld_ready !== 1'b0 || bus.rf_write !== 1'b1 || bus.A3 !== 5'd1 || bus.WB_data !== d[0]) begin
         $display("FAIL drain0: got rdy=%b we=%b a3=%0d d=%h want 0/1/1/%h", bus.ld_ready, bus.rf_write, bus.A3, bus.WB_data, d[0]);
         n_fail++;
      end
      step();
      for (int j = 1; j < 5; j++) begin
         #1;
         n_checks++;
         if (bus.rf_write !== 1'b1 || bus.A3 !== 5'(j + 1) || bus.WB_data !== d[j] || (j == 1 && bus.ld_ready !== 1'b1)) begin
            $display("FAIL drain%0d: got we=%b a3=%0d d=%h rdy=%b want 1/%0d/%h", j, bus.rf_write, bus.A3, bus.WB_data,
                     bus.ld_ready, j + 1, d[j]);
            n_fail++;
         end
         step();
         bus.ld_valid = 1'b0;
      end
      for (int i = 0; i < 6; i++) begin
         bus.ld_valid = (i < 5);
         bus.ld_rd    = 5'(i + 6);
         bus.ld_data  = (i < 5) ? d[i + 5] : 32'd0;
         #1;
         n_checks++;
         if (i == 0) begin
            if (bus.rf_write !== 1'b0) begin
               $display("FAIL wrap_empty: got we=%b want 0", bus.rf_write);
               n_fail++;
            end
         end else if (bus.rf_write !== 1'b1 || bus.A3 !== 5'(i + 5) || bus.WB_data !== d[i + 4]) begin
            $display("FAIL wrap%0d: got we=%b a3=%0d d=%h want 1/%0d/%h", i, bus.rf_write, bus.A3, bus.WB_data, i + 5, d[i + 4]);
            n_fail++;
         end
         step();
      end
      idle_inputs();
      #1;
      n_checks++;
      if (bus.rf_write !== 1'b0 || bus.ld_ready !== 1'b1) begin
         $display("FAIL wrap_done: got we=%b rdy=%b want 0/1", bus.rf_write, bus.ld_ready);
         n_fail++;
      end
      step();
   endtask

   task automatic test_push_pop();
      logic [31:0] e [3];
      e[0] = 32'h0000_E0E0;
      e[1] = 32'h0000_E1E1;
      e[2] = 32'h0000_E2E2;
      idle_inputs();
      bus.pipe_wb_valid = 1'b1;
      bus.pipe_wb_rd    = 5'd2;
      bus.pipe_wb_data  = 32'h5555_AAAA;
      for (int i = 0; i < 2; i++) begin
         bus.ld_valid = 1'b1;
         bus.ld_rd    = 5'(20 + i);
         bus.ld_data  = e[i];
         step();
      end
      bus.pipe_wb_valid = 1'b0;
      bus.ld_rd         = 5'd22;
      bus.ld_data       = e[2];
      #1;
      n_checks++;
      if (bus.ld_ready !== 1'b1 || bus.A3 !== 5'd20 || bus.WB_data !== e[0]) begin
         $display("FAIL pp_pop0: got rdy=%b a3=%0d d=%h want 1/20/%h", bus.ld_ready, bus.A3, bus.WB_data, e[0]);
         n_fail++;
      end
      step();
      bus.ld_valid = 1'b0;
      for (int j = 1; j < 3; j++) begin
         #1;
         n_checks++;
         if (bus.rf_write !== 1'b1 || bus.A3 !== 5'(20 + j) || bus.WB_data !== e[j]) begin
            $display("FAIL pp_pop%0d: got we=%b a3=%0d d=%h want 1/%0d/%h", j, bus.rf_write, bus.A3, bus.WB_data, 20 + j, e[j]);
            n_fail++;
         end
         step();
      end
      #1;
      n_checks++;
      if (bus.rf_write !== 1'b0) begin
         $display("FAIL pp_empty: got we=%b want 0", bus.rf_write);
         n_fail++;
      end
      step();
   endtask

   task automatic test_reset_mid();
      idle_inputs();
      bus.pipe_wb_valid = 1'b1;
      bus.pipe_wb_rd    = 5'd1;
      bus.pipe_wb_data  = 32'h7777_7777;
      bus.rs1           = 5'd8;
      bus.rs2           = 5'd9;
      bus.rd_q          = 5'd10;
      for (int i = 0; i < 3; i++) begin
         bus.ld_issue    = 1'b1;
         bus.ld_issue_rd = 5'(8 + i);
         bus.ld_valid    = 1'b1;
         bus.ld_rd       = 5'(8 + i);
         bus.ld_data     = 32'hF000_0000 + 32'(i);
         step();
      end
      bus.ld_issue = 1'b0;
      bus.ld_valid = 1'b0;
      #1;
      n_checks++;
      if ({bus.rs1_pending, bus.rs2_pending, bus.rd_pending} !== 3'b111 || bus.A3 !== 5'd1) begin
         $display("FAIL mid_pre: got pend=%b a3=%0d want 111/1", {bus.rs1_pending, bus.rs2_pending, bus.rd_pending}, bus.A3);
         n_fail++;
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if ({bus.rs1_pending, bus.rs2_pending, bus.rd_pending} !== 3'b000 || bus.rf_write !== 1'b0 ||
          bus.A3 !== 5'd0 || bus.WB_data !== 32'd0 || bus.pipe_stall !== 1'b0) begin
         $display("FAIL mid_rst: got pend=%b we=%b a3=%0d d=%h stall=%b want 000/0/0/0/0",
                  {bus.rs1_pending, bus.rs2_pending, bus.rd_pending}, bus.rf_write, bus.A3, bus.WB_data, bus.pipe_stall);
         n_fail++;
      end
      step();
      rst = 1'b0;
      bus.pipe_wb_valid = 1'b0;
      #1;
      n_checks++;
      if (bus.rf_write !== 1'b0 || bus.ld_ready !== 1'b1) begin
         $display("FAIL mid_after: got we=%b rdy=%b want 0/1", bus.rf_write, bus.ld_ready);
         n_fail++;
      end
      step();
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      idle_inputs();
      test_reset();
      test_single_load();
      test_starve();
      test_full_fifo();
      test_push_pop();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
